ebus_arbiter: RTL

//  Owns the EBUS: grants exactly one requester (APR,CON,CRA,CTL,DTE,EDP,IR,MBZ,MTR,PIC,SCD,SHM,VMA)
//  the right to drive EBUS.data, one at a time, with a mandatory dead cycle between owners.

---
 rtl/ebus_arb_pkg.sv | 29 ++
 rtl/ebus_rr_pick.sv | 52 +++++
 rtl/ebus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ebus_arb_pkg.sv
// Shared definitions for the EBUS arbiter and the EBUS data mux.
// Unit indices fix the mux ordering, so grant bit i always selects the same unit.
package ebus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } arbState_t;

    // Width of a binary requester index (covers up to 16 requesters)
    localparam int IDX_W = 4;

    // Requester positions on the EBUS mux
    localparam int APR_IDX = 0;
    localparam int CON_IDX = 1;
    localparam int CRA_IDX = 2;
    localparam int CTL_IDX = 3;
    localparam int DTE_IDX = 4;
    localparam int EDP_IDX = 5;
    localparam int IR_IDX  = 6;
    localparam int MBZ_IDX = 7;
    localparam int MTR_IDX = 8;
    localparam int PIC_IDX = 9;
    localparam int SCD_IDX = 10;
    localparam int SHM_IDX = 11;
    localparam int VMA_IDX = 12;

endpackage

// File: rtl/ebus_rr_pick.sv
// Combinational winner selection for the EBUS arbiter.
// The priority unit wins outright whenever it requests; otherwise the first
// requester at or above rr_ptr wins, wrapping around to the lowest requester.
module ebus_rr_pick
    import ebus_arb_pkg::*;
#(
    parameter int NREQ     = 13,
    parameter int PRIO_IDX = 9
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [NREQ-1:0] upper_req;
    logic [NREQ-1:0] cand;

    // Requests at or above the round-robin pointer get first claim
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
            assign upper_req[gi] = req[gi] && (IDX_W'(gi) >= rr_ptr);
        end
    endgenerate

    // Fall back to the lowest request overall when nothing sits above the pointer
    assign cand      = (|upper_req) ? upper_req : req;
    assign win_valid = |req;

    // Priority unit first, else lowest set candidate bit
    always_comb begin
        win_idx = '0;
        if (req[PRIO_IDX]) begin
            win_idx = IDX_W'(PRIO_IDX);
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_idx = IDX_W'(i);
                end
            end
        end
    end

    // Decode the chosen index back to a one-hot select
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = win_valid && (win_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/ebus_arbiter.sv
// EBUS ownership arbiter: grants one requester at a time, forces a single
// zero-grant turnaround cycle between owners, revokes owners that hold the bus
// too long, and flags any unit driving the bus without a grant.
module ebus_arbiter
    import ebus_arb_pkg::*;
#(
    parameter int NREQ     = 13,
    parameter int PRIO_IDX = 9,
    parameter int HOLD_MAX = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  driving,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grantIdx,
    output logic             busy,
    output logic             holdErr,
    output logic             conflictErr,
    input  logic             errClr
);

    localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    arbState_t        state_reg, state_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [NREQ-1:0]  prev_grant_reg;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             hold_err_reg, hold_err_next;
    logic             conflict_err_reg;

    logic [NREQ-1:0]  win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             owner_req;
    logic             hold_done;
    logic             conflict_set;

    ebus_rr_pick #(
        .NREQ     (NREQ),
        .PRIO_IDX (PRIO_IDX)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_reg),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    assign owner_req = |(req & grant_reg);
    // hold_cnt counts grant cycles already completed; the current cycle is the HOLD_MAX-th
    assign hold_done = (hold_cnt_reg >= CNT_W'(HOLD_MAX - 1));
    // The previous owner gets one cycle after grant falls to release its drivers
    assign conflict_set = |(driving & ~(grant_reg | prev_grant_reg));

    // Next-state, grant and bookkeeping decisions
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        idx_next      = idx_reg;
        hold_cnt_next = hold_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_err_next = errClr ? 1'b0 : hold_err_reg;

        case (state_reg)
            ARB_IDLE, ARB_TURN: begin
                if (win_valid) begin
                    state_next    = ARB_GRANT;
                    grant_next    = win_onehot;
                    idx_next      = win_idx;
                    hold_cnt_next = '0;
                    if (win_idx != IDX_W'(PRIO_IDX)) begin
                        rr_ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    end
                end else begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    idx_next   = '0;
                end
            end
            ARB_GRANT: begin
                if (hold_cnt_reg != CNT_W'(HOLD_MAX)) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
                if (!owner_req || hold_done) begin
                    state_next = ARB_TURN;
                    grant_next = '0;
                    idx_next   = '0;
                    // Only a forced revoke counts as an overrun
                    if (owner_req) begin
                        hold_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
                idx_next   = '0;
            end
        endcase
    end

    // State register; reset drops any grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ARB_IDLE;
            grant_reg        <= '0;
            prev_grant_reg   <= '0;
            idx_reg          <= '0;
            hold_cnt_reg     <= '0;
            rr_ptr_reg       <= '0;
            hold_err_reg     <= 1'b0;
            conflict_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            prev_grant_reg <= grant_reg;
            idx_reg        <= idx_next;
            hold_cnt_reg   <= hold_cnt_next;
            rr_ptr_reg     <= rr_ptr_next;
            hold_err_reg   <= hold_err_next;
            // A new conflict takes precedence over a clear in the same cycle
            if (conflict_set) begin
                conflict_err_reg <= 1'b1;
            end else if (errClr) begin
                conflict_err_reg <= 1'b0;
            end
        end
    end

    assign grant       = grant_reg;
    assign grantIdx    = idx_reg;
    assign busy        = |grant_reg;
    assign holdErr     = hold_err_reg;
    assign conflictErr = conflict_err_reg;

endmodule
